// File: rtl/multicycle_core.sv
// -----------------------------------------------------------------------------
// multicycle_core
//   Multi-cycle RV32I-subset core (lw, sw, add, sub, and, or, slt, addi, beq,
//   jal). One FSM sequences every instruction through a shared ALU and a
//   single unified instruction/data memory port with a req/ready handshake.
//   An illegal instruction parks the core in HALT until reset.
//
// Parameters
//   RESET_PC   PC loaded on reset.
//   REG_COUNT  architectural registers, 16 (RV32E-style) or 32.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   mem_req    memory transaction request
//   mem_we     1 = write, 0 = read (valid while mem_req=1)
//   mem_addr   word-aligned byte address (0 when idle)
//   mem_wdata  store data (0 unless writing)
//   mem_rdata  read data, valid whenever mem_ready=1
//   mem_ready  completes the transaction on a rising edge with mem_req=1
//   halt       core stopped on an illegal instruction
//   pc_dbg     current PC
// -----------------------------------------------------------------------------
module multicycle_core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          REG_COUNT = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halt,
    output logic [31:0] pc_dbg
);

    localparam bit SMALL_RF = (REG_COUNT == 16);
    localparam int IDX_W    = SMALL_RF ? 4 : 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_HALT
    } state_t;

    state_t      state, state_nx, dec_state;
    logic [31:0] pc, old_pc, ir, reg_a, reg_b, alu_out, mdr;
    logic [31:0] rf [REG_COUNT];

    logic [6:0]       opcode, funct7;
    logic [2:0]       funct3;
    logic [IDX_W-1:0] rs1, rs2, rd;
    logic [31:0]      imm_i, imm_s, imm_b, imm_j;
    logic             legal, use_rd, use_rs1, use_rs2, bad_reg;
    logic [31:0]      alu_y, rf_wd, addr_sel;
    logic             rf_we, mem_done;

    // Instruction fields and sign-extended immediates.
    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rd     = ir[7  +: IDX_W];
    assign rs1    = ir[15 +: IDX_W];
    assign rs2    = ir[20 +: IDX_W];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // Opcode/funct legality and the register fields each format really uses.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        legal     = 1'b0;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        dec_state = S_HALT;
        case (opcode)
            OP_LOAD: begin
                legal = (funct3 == 3'b010); use_rd = 1'b1; use_rs1 = 1'b1;
                dec_state = S_MEMADR;
            end
            OP_STORE: begin
                legal = (funct3 == 3'b010); use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec_state = S_MEMADR;
            end
            OP_REG: begin
                legal = ((funct7 == 7'b0000000) &&
                         (funct3 == 3'b000 || funct3 == 3'b010 ||
                          funct3 == 3'b110 || funct3 == 3'b111)) ||
                        ((funct7 == 7'b0100000) && (funct3 == 3'b000));
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec_state = S_EXEC_R;
            end
            OP_IMM: begin
                legal = (funct3 == 3'b000); use_rd = 1'b1; use_rs1 = 1'b1;
                dec_state = S_EXEC_I;
            end
            OP_BRANCH: begin
                legal = (funct3 == 3'b000); use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec_state = S_BEQ;
            end
            OP_JAL: begin
                legal = 1'b1; use_rd = 1'b1;
                dec_state = S_JAL;
            end
            default: ;
        endcase
    end

    // A 16-register build rejects any used register field naming x16..x31.
    assign bad_reg = SMALL_RF && ((use_rd && ir[11]) || (use_rs1 && ir[19]) ||
                                  (use_rs2 && ir[24]));

    // Shared ALU: address generation, addi and the R-type operations.
    always_comb begin
        alu_y = reg_a + ((opcode == OP_STORE) ? imm_s : imm_i);
        if (state == S_EXEC_R) begin
            case (funct3)
                3'b000:  alu_y = funct7[5] ? (reg_a - reg_b) : (reg_a + reg_b);
                3'b010:  alu_y = {31'd0, $signed(reg_a) < $signed(reg_b)};
                3'b110:  alu_y = reg_a | reg_b;
                3'b111:  alu_y = reg_a & reg_b;
                default: alu_y = '0;
            endcase
        end
    end

    // Register-file write port (x0 is filtered at the write itself).
    always_comb begin
        rf_we = 1'b0;
        rf_wd = alu_out;
        case (state)
            S_MEMWB: begin rf_we = 1'b1; rf_wd = mdr; end
            S_ALUWB: rf_we = 1'b1;
            S_JAL:   begin rf_we = 1'b1; rf_wd = old_pc + 32'd4; end
            default: ;
        endcase
    end

    // Gating with rst keeps the port idle during reset even though the state
    // register already sits in FETCH, and drops a live request the instant
    // reset asserts.
    assign mem_req   = rst && (state == S_FETCH || state == S_MEMREAD ||
                               state == S_MEMWRITE);
    assign mem_we    = mem_req && (state == S_MEMWRITE);
    assign addr_sel  = (state == S_FETCH) ? pc : alu_out;
    assign mem_addr  = mem_req ? {addr_sel[31:2], 2'b00} : '0;
    assign mem_wdata = mem_we ? reg_b : '0;
    assign mem_done  = mem_req && mem_ready;
    assign halt      = (state == S_HALT);
    assign pc_dbg    = pc;

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:    if (mem_done) state_nx = S_DECODE;
            S_DECODE:   state_nx = (legal && !bad_reg) ? dec_state : S_HALT;
            S_MEMADR:   state_nx = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_done) state_nx = S_MEMWB;
            S_MEMWRITE: if (mem_done) state_nx = S_FETCH;
            S_EXEC_R,
            S_EXEC_I:   state_nx = S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BEQ,
            S_JAL:      state_nx = S_FETCH;
            default:    state_nx = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) state <= S_FETCH;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            old_pc  <= '0;
            ir      <= '0;
            reg_a   <= '0;
            reg_b   <= '0;
            alu_out <= '0;
            mdr     <= '0;
            // NOTE: the register file is architecturally zero after reset, so
            // it is built from flops and cleared here; a RAM macro could not be.
            for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_done) begin
                    ir     <= mem_rdata;
                    old_pc <= pc;
                    pc     <= pc + 32'd4;
                end
                S_DECODE: begin
                    reg_a <= rf[rs1];
                    reg_b <= rf[rs2];
                end
                S_MEMADR, S_EXEC_R, S_EXEC_I: alu_out <= alu_y;
                S_MEMREAD: if (mem_done) mdr <= mem_rdata;
                S_BEQ:     if (reg_a == reg_b) pc <= old_pc + imm_b;
                S_JAL:     pc <= old_pc + imm_j;
                default: ;
            endcase
            if (rf_we && rd != '0) rf[rd] <= rf_wd;
        end
    end

endmodule
